// File: rtl/sum_disp_pkg.sv
// Shared types and constants for the sum display driver: FSM states, digit
// select, active-low segment codes ({g,f,e,d,c,b,a}) and digit-enable patterns.
package sum_disp_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_e;

   typedef enum logic {
      SEL_ONES = 1'b0,
      SEL_TENS = 1'b1
   } digit_sel_e;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   localparam logic [1:0] AN_OFF  = 2'b11;
   localparam logic [1:0] AN_ONES = 2'b10;
   localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder for a common-anode display.
// Codes 10..15 are not digits and decode to an unlit digit.
module seg7_decode
   import sum_disp_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      unique case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sum_display_driver.sv
// Captures the 4-bit result of a 3-bit adder and multiplexes it onto a
// two-digit seven-segment display. Define SUM_DISPLAY_LEADING_ZERO_BLANK_EN
// to leave the tens digit dark when it would show 0.
module sum_display_driver
   import sum_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] S,
   input  logic       Cout,
   input  logic       LOAD,
   input  logic       CLR,
   output logic [3:0] VALUE,
   output logic       VALID,
   output logic [1:0] AN,
   output logic [6:0] SEG
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   state_e           state_q, state_d;
   logic [3:0]       value_q, value_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   digit_sel_e       sel_q, sel_d;
   logic [1:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;

   logic             cnt_wrap;
   logic             tens;
   logic [3:0]       ones;
   logic [3:0]       digit;
   logic [6:0]       dec_seg;

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      value_d = value_q;
      unique case (state_q)
         BLANK: begin
            if (CLR) begin
               value_d = 4'd0;
            end else if (LOAD) begin
               state_d = SHOW;
               value_d = {Cout, S};
            end
         end
         SHOW: begin
            if (CLR) begin
               state_d = BLANK;
               value_d = 4'd0;
            end else if (LOAD) begin
               value_d = {Cout, S};
            end
         end
         default: begin
            state_d = BLANK;
            value_d = 4'd0;
         end
      endcase
   end

   // The refresh timebase free-runs in both states; loads never disturb it.
   always_comb begin
      cnt_wrap = (cnt_q == CNT_LAST);
      cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
      sel_d    = sel_q;
      if (cnt_wrap) begin
         sel_d = (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
      end
   end

   always_comb begin
      tens  = (value_q >= 4'd10);
      ones  = tens ? (value_q - 4'd10) : value_q;
      digit = (sel_q == SEL_TENS) ? {3'b000, tens} : ones;
   end

   seg7_decode u_seg7_decode (
      .digit_i (digit),
      .seg_o   (dec_seg)
   );

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      if (state_q == SHOW) begin
         if (sel_q == SEL_ONES) begin
            an_d  = AN_ONES;
            seg_d = dec_seg;
         end else begin
`ifdef SUM_DISPLAY_LEADING_ZERO_BLANK_EN
            if (tens) begin
               an_d  = AN_TENS;
               seg_d = dec_seg;
            end
`else
            an_d  = AN_TENS;
            seg_d = dec_seg;
`endif
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= BLANK;
         value_q <= 4'd0;
         cnt_q   <= '0;
         sel_q   <= SEL_ONES;
         an_q    <= AN_OFF;
         seg_q   <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign VALUE = value_q;
   assign VALID = (state_q == SHOW);
   assign AN    = an_q;
   assign SEG   = seg_q;

endmodule

// File: tb/tb_sum_display_driver.sv
// Directed self-checking bench for sum_display_driver with REFRESH_DIV=4.
// Honours SUM_DISPLAY_LEADING_ZERO_BLANK_EN when choosing tens-slot expectations.
module tb_sum_display_driver;

   logic       CLK;
   logic       RST;
   logic [2:0] S;
   logic       Cout;
   logic       LOAD;
   logic       CLR;
   logic [3:0] VALUE;
   logic       VALID;
   logic [1:0] AN;
   logic [6:0] SEG;

   int total = 0;
   int bad   = 0;

`ifdef SUM_DISPLAY_LEADING_ZERO_BLANK_EN
   localparam logic [1:0] ZT_AN  = 2'b11;
   localparam logic [6:0] ZT_SEG = 7'b1111111;
`else
   localparam logic [1:0] ZT_AN  = 2'b01;
   localparam logic [6:0] ZT_SEG = 7'b1000000;
`endif

   // Digit vectors: captured value, expected ones-slot code, tens digit is 1.
   localparam int NV = 7;
   localparam logic [3:0] DV [NV] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15, 4'd0};
   localparam logic [6:0] DS [NV] = '{7'b0000010, 7'b1111000, 7'b0000000,
                                      7'b0010000, 7'b1000000, 7'b0010010,
                                      7'b1000000};
   localparam logic       DT [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   sum_display_driver #(.REFRESH_DIV(4)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .S     (S),
      .Cout  (Cout),
      .LOAD  (LOAD),
      .CLR   (CLR),
      .VALUE (VALUE),
      .VALID (VALID),
      .AN    (AN),
      .SEG   (SEG)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance through one rising edge and land on the following falling edge.
   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Ends on a falling edge with RST low; the next rising edge is edge 1.
   task automatic do_reset();
      @(negedge CLK);
      RST  = 1'b1;
      LOAD = 1'b0;
      CLR  = 1'b0;
      S    = 3'b000;
      Cout = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total++; if (VALUE !== 4'd0)       begin bad++; $display("FAIL reset_value: got %0d want 0", VALUE); end
      total++; if (VALID !== 1'b0)       begin bad++; $display("FAIL reset_valid: got %b want 0", VALID); end
      total++; if (AN !== 2'b11)         begin bad++; $display("FAIL reset_an: got %b want 11", AN); end
      total++; if (SEG !== 7'b1111111)   begin bad++; $display("FAIL reset_seg: got %b want 1111111", SEG); end
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         step();
         total++; if (AN !== 2'b11 || SEG !== 7'b1111111 || VALID !== 1'b0) begin
            bad++; $display("FAIL blank_idle edge %0d: got AN=%b SEG=%b VALID=%b want 11 1111111 0", k, AN, SEG, VALID);
         end
      end
   endtask

   task automatic test_capture();
      logic [1:0] exp_an;
      logic [6:0] exp_seg;
      do_reset();
      S = 3'b101; Cout = 1'b1; LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      total++; if (VALUE !== 4'd13) begin bad++; $display("FAIL cap_value: got %0d want 13", VALUE); end
      total++; if (VALID !== 1'b1)  begin bad++; $display("FAIL cap_valid: got %b want 1", VALID); end
      total++; if (AN !== 2'b11)    begin bad++; $display("FAIL cap_an_lag: got %b want 11", AN); end
      // Digit select flips at edges 4, 8, ...; AN/SEG follow one edge later.
      for (int k = 2; k <= 12; k++) begin
         step();
         exp_an  = (((k - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
         exp_seg = (exp_an == 2'b10) ? 7'b0110000 : 7'b1111001;
         total++; if (AN !== exp_an || SEG !== exp_seg) begin
            bad++; $display("FAIL cap_slot edge %0d: got AN=%b SEG=%b want AN=%b SEG=%b", k, AN, SEG, exp_an, exp_seg);
         end
      end
   endtask

   task automatic test_async_reset();
      #1 RST = 1'b1;
      #1;
      total++; if (AN !== 2'b11 || SEG !== 7'b1111111 || VALID !== 1'b0 || VALUE !== 4'd0) begin
         bad++; $display("FAIL async_reset: got AN=%b SEG=%b VALID=%b VALUE=%0d want 11 1111111 0 0", AN, SEG, VALID, VALUE);
      end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_priority();
      do_reset();
      S = 3'b111; Cout = 1'b0; LOAD = 1'b1;
      step();
      CLR = 1'b1; S = 3'b010;
      step();
      LOAD = 1'b0; CLR = 1'b0;
      total++; if (VALUE !== 4'd0 || VALID !== 1'b0) begin
         bad++; $display("FAIL prio_state: got VALUE=%0d VALID=%b want 0 0", VALUE, VALID);
      end
      total++; if (AN !== 2'b10 || SEG !== 7'b1111000) begin
         bad++; $display("FAIL prio_lag: got AN=%b SEG=%b want 10 1111000", AN, SEG);
      end
      step();
      total++; if (AN !== 2'b11 || SEG !== 7'b1111111) begin
         bad++; $display("FAIL prio_blank: got AN=%b SEG=%b want 11 1111111", AN, SEG);
      end
      S = 3'b001; Cout = 1'b0; LOAD = 1'b1;
      step();
      LOAD = 1'b0; CLR = 1'b1;
      step();
      CLR = 1'b0;
      total++; if (VALUE !== 4'd0 || VALID !== 1'b0) begin
         bad++; $display("FAIL clr_only: got VALUE=%0d VALID=%b want 0 0", VALUE, VALID);
      end
   endtask

   task automatic test_leading_zero();
      do_reset();
      S = 3'b100; Cout = 1'b0; LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      step();
      total++; if (AN !== 2'b10 || SEG !== 7'b0011001) begin
         bad++; $display("FAIL lz_ones: got AN=%b SEG=%b want 10 0011001", AN, SEG);
      end
      step(); step(); step();
      total++; if (AN !== ZT_AN || SEG !== ZT_SEG) begin
         bad++; $display("FAIL lz_tens: got AN=%b SEG=%b want %b %b", AN, SEG, ZT_AN, ZT_SEG);
      end
   endtask

   task automatic test_recapture();
      do_reset();
      S = 3'b010; Cout = 1'b0; LOAD = 1'b1;
      step();
      S = 3'b101;
      step();
      LOAD = 1'b0;
      total++; if (VALUE !== 4'd5) begin bad++; $display("FAIL recap_value: got %0d want 5", VALUE); end
      total++; if (SEG !== 7'b0100100) begin bad++; $display("FAIL recap_seg_old: got %b want 0100100", SEG); end
      step();
      total++; if (SEG !== 7'b0010010) begin bad++; $display("FAIL recap_seg_new: got %b want 0010010", SEG); end
      step();
      total++; if (AN !== 2'b10) begin bad++; $display("FAIL recap_ones_end: got %b want 10", AN); end
      step();
      total++; if (AN !== ZT_AN) begin bad++; $display("FAIL recap_tens_start: got %b want %b", AN, ZT_AN); end
      step(); step(); step();
      total++; if (AN !== ZT_AN) begin bad++; $display("FAIL recap_tens_end: got %b want %b", AN, ZT_AN); end
      step();
      total++; if (AN !== 2'b10) begin bad++; $display("FAIL recap_ones_again: got %b want 10", AN); end
   endtask

   task automatic test_digits();
      for (int i = 0; i < NV; i++) begin
         do_reset();
         {Cout, S} = DV[i]; LOAD = 1'b1;
         step();
         LOAD = 1'b0;
         total++; if (VALUE !== DV[i] || VALID !== 1'b1) begin
            bad++; $display("FAIL dig_value[%0d]: got %0d/%b want %0d/1", i, VALUE, VALID, DV[i]);
         end
         step();
         total++; if (AN !== 2'b10 || SEG !== DS[i]) begin
            bad++; $display("FAIL dig_ones[%0d]: got AN=%b SEG=%b want 10 %b", i, AN, SEG, DS[i]);
         end
         step(); step(); step();
         if (DT[i]) begin
            total++; if (AN !== 2'b01 || SEG !== 7'b1111001) begin
               bad++; $display("FAIL dig_tens[%0d]: got AN=%b SEG=%b want 01 1111001", i, AN, SEG);
            end
         end else begin
            total++; if (AN !== ZT_AN || SEG !== ZT_SEG) begin
               bad++; $display("FAIL dig_tens[%0d]: got AN=%b SEG=%b want %b %b", i, AN, SEG, ZT_AN, ZT_SEG);
            end
         end
      end
   endtask

   initial begin
      RST  = 1'b1;
      S    = 3'b000;
      Cout = 1'b0;
      LOAD = 1'b0;
      CLR  = 1'b0;
      test_reset();
      test_capture();
      test_async_reset();
      test_priority();
      test_leading_zero();
      test_recapture();
      test_digits();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
